// File: rtl/reduction_job_arbiter.sv
// reduction_job_arbiter
//   Shares one streaming reduction pipeline between two requester streams at
//   job (tlast-delimited packet) granularity. Input jobs are granted round-robin;
//   the owner of each granted job is queued as a tag so the pipeline's output
//   stream and scalar results are steered back to the right requester in order.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   en                    arbitration enable (checked only when idle)
//   s0_*/s1_*             requester input streams (AXI-Stream style)
//   p_in_*                pipeline input stream
//   p_out_*               pipeline output stream
//   p_res_*               pipeline scalar result, no backpressure
//   m0_*/m1_*             per-requester output streams
//   r0_*/r1_*             per-requester scalar results
//   jobs0/jobs1           jobs granted per requester (wrapping)
//   err_orphan            sticky: scalar result arrived with no job outstanding
module reduction_job_arbiter #(
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned RES_BITS  = 64,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 en,
  input  logic                 s0_tvalid,
  output logic                 s0_tready,
  input  logic [DATA_BITS-1:0] s0_tdata,
  input  logic                 s0_tlast,
  input  logic                 s1_tvalid,
  output logic                 s1_tready,
  input  logic [DATA_BITS-1:0] s1_tdata,
  input  logic                 s1_tlast,
  output logic                 p_in_tvalid,
  input  logic                 p_in_tready,
  output logic [DATA_BITS-1:0] p_in_tdata,
  output logic                 p_in_tlast,
  input  logic                 p_out_tvalid,
  output logic                 p_out_tready,
  input  logic [DATA_BITS-1:0] p_out_tdata,
  input  logic                 p_out_tlast,
  input  logic                 p_res_valid,
  input  logic [RES_BITS-1:0]  p_res_data,
  input  logic                 p_res_last,
  output logic                 m0_tvalid,
  input  logic                 m0_tready,
  output logic [DATA_BITS-1:0] m0_tdata,
  output logic                 m0_tlast,
  output logic                 m1_tvalid,
  input  logic                 m1_tready,
  output logic [DATA_BITS-1:0] m1_tdata,
  output logic                 m1_tlast,
  output logic                 r0_valid,
  output logic [RES_BITS-1:0]  r0_data,
  output logic                 r0_last,
  output logic                 r1_valid,
  output logic [RES_BITS-1:0]  r1_data,
  output logic                 r1_last,
  output logic [31:0]          jobs0,
  output logic [31:0]          jobs1,
  output logic                 err_orphan
);

  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic                 owner;
  logic                 rr;

  // Both tag FIFOs are always pushed together with the same tag, so they share
  // storage and the write pointer; only the read pointers differ.
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW:0]          wr_ptr;
  logic [PW:0]          out_rd;
  logic [PW:0]          res_rd;

  logic out_empty, out_full, res_empty, res_full;
  logic head, res_head;
  logic grant, winner, job_end, out_pop, res_pop;

  assign out_empty = (wr_ptr == out_rd);
  assign out_full  = (wr_ptr[PW] != out_rd[PW]) && (wr_ptr[PW-1:0] == out_rd[PW-1:0]);
  assign res_empty = (wr_ptr == res_rd);
  assign res_full  = (wr_ptr[PW] != res_rd[PW]) && (wr_ptr[PW-1:0] == res_rd[PW-1:0]);
  assign head      = tag_mem[out_rd[PW-1:0]];
  assign res_head  = tag_mem[res_rd[PW-1:0]];

  assign grant  = (state == IDLE) && en && (s0_tvalid || s1_tvalid) && !out_full && !res_full;
  // Favour rr when it is requesting, otherwise the other side.
  assign winner = rr ? (s1_tvalid ? 1'b1 : 1'b0) : (s0_tvalid ? 1'b0 : 1'b1);

  // Input forwarding from the owner while a job is in progress.
  always_comb begin
    p_in_tvalid = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    p_in_tdata  = owner ? s1_tdata : s0_tdata;
    p_in_tlast  = owner ? s1_tlast : s0_tlast;
    if (state == BUSY) begin
      p_in_tvalid = owner ? s1_tvalid : s0_tvalid;
      s0_tready   = ~owner & p_in_tready;
      s1_tready   = owner & p_in_tready;
    end
  end

  assign job_end = (state == BUSY) && p_in_tvalid && p_in_tready && p_in_tlast;

  // Output stream steering by the head tag; stalls while nothing is queued.
  assign m0_tvalid    = p_out_tvalid & ~out_empty & ~head;
  assign m1_tvalid    = p_out_tvalid & ~out_empty & head;
  assign m0_tdata     = p_out_tdata;
  assign m1_tdata     = p_out_tdata;
  assign m0_tlast     = p_out_tlast;
  assign m1_tlast     = p_out_tlast;
  assign p_out_tready = (head ? m1_tready : m0_tready) & ~out_empty;
  assign out_pop      = p_out_tvalid & p_out_tready & p_out_tlast;

  // Scalar result steering; data is zeroed when not valid for that side.
  assign r0_valid = p_res_valid & ~res_empty & ~res_head;
  assign r1_valid = p_res_valid & ~res_empty & res_head;
  assign r0_data  = r0_valid ? p_res_data : '0;
  assign r1_data  = r1_valid ? p_res_data : '0;
  assign r0_last  = r0_valid & p_res_last;
  assign r1_last  = r1_valid & p_res_last;
  assign res_pop  = p_res_valid & p_res_last & ~res_empty;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr         <= 1'b0;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      out_rd     <= '0;
      res_rd     <= '0;
      jobs0      <= '0;
      jobs1      <= '0;
      err_orphan <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state                     <= BUSY;
            owner                     <= winner;
            tag_mem[wr_ptr[PW-1:0]]   <= winner;
            wr_ptr                    <= wr_ptr + PTR_ONE;
            if (winner) jobs1 <= jobs1 + 32'd1;
            else        jobs0 <= jobs0 + 32'd1;
          end
        end
        BUSY: begin
          if (job_end) begin
            state <= IDLE;
            rr    <= ~owner;
          end
        end
        default: state <= IDLE;
      endcase
      if (out_pop) out_rd <= out_rd + PTR_ONE;
      if (res_pop) res_rd <= res_rd + PTR_ONE;
      if (p_res_valid && res_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reduction_job_arbiter.sv
module tb_reduction_job_arbiter;

  localparam int unsigned DW = 512;
  localparam int unsigned RW = 64;
  localparam int unsigned TD = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          en = 1'b1;
  logic          s0_tvalid = 1'b0, s0_tready, s0_tlast = 1'b0;
  logic          s1_tvalid = 1'b0, s1_tready, s1_tlast = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic          p_in_tvalid, p_in_tready = 1'b1, p_in_tlast;
  logic [DW-1:0] p_in_tdata;
  logic          p_out_tvalid = 1'b0, p_out_tready, p_out_tlast = 1'b0;
  logic [DW-1:0] p_out_tdata = '0;
  logic          p_res_valid = 1'b0, p_res_last = 1'b0;
  logic [RW-1:0] p_res_data = '0;
  logic          m0_tvalid, m0_tready = 1'b1, m0_tlast;
  logic          m1_tvalid, m1_tready = 1'b1, m1_tlast;
  logic [DW-1:0] m0_tdata, m1_tdata;
  logic          r0_valid, r0_last, r1_valid, r1_last;
  logic [RW-1:0] r0_data, r1_data;
  logic [31:0]   jobs0, jobs1;
  logic          err_orphan;

  always #5 aclk = ~aclk;

  reduction_job_arbiter #(.DATA_BITS(DW), .RES_BITS(RW), .TAG_DEPTH(TD)) dut (
    .aclk(aclk), .areset(areset), .en(en),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .p_in_tvalid(p_in_tvalid), .p_in_tready(p_in_tready), .p_in_tdata(p_in_tdata), .p_in_tlast(p_in_tlast),
    .p_out_tvalid(p_out_tvalid), .p_out_tready(p_out_tready), .p_out_tdata(p_out_tdata), .p_out_tlast(p_out_tlast),
    .p_res_valid(p_res_valid), .p_res_data(p_res_data), .p_res_last(p_res_last),
    .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tdata(m0_tdata), .m0_tlast(m0_tlast),
    .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tdata(m1_tdata), .m1_tlast(m1_tlast),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last),
    .jobs0(jobs0), .jobs1(jobs1), .err_orphan(err_orphan)
  );

  typedef struct { logic [DW-1:0] d; logic l; int unsigned t; } pbeat_t;
  typedef struct { logic [DW-1:0] d; logic l; } mbeat_t;

  pbeat_t        pipe_q[$];
  mbeat_t        exp_m0[$], exp_m1[$];
  logic [RW-1:0] exp_r0[$], exp_r1[$];
  int            grant_log[$], m_order[$], r_order[$];
  int unsigned   first_cyc[$], last_cyc[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned pipe_delay = 0;
  int unsigned jc = 0, res_cnt = 0;
  int unsigned m_beats0 = 0, m_beats1 = 0, r_seen0 = 0, r_seen1 = 0;
  logic        s_first0 = 1'b1, s_first1 = 1'b1, pin_first = 1'b1;
  logic        orphan_req = 1'b0;
  logic        pin_hs, pout_hs, pout_last;
  pbeat_t      nb;
  mbeat_t      eb;
  logic [RW-1:0] er;

  // Pipeline model + scoreboard. Samples at negedge, drives #1 after posedge.
  always begin
    @(negedge aclk);
    pin_hs = 1'b0; pout_hs = 1'b0; pout_last = 1'b0;
    if (!areset) begin
      if (s0_tvalid && s0_tready) begin
        exp_m0.push_back('{s0_tdata, s0_tlast});
        if (s_first0) begin exp_r0.push_back(64'h2A + 64'(jc)); jc++; grant_log.push_back(0); end
        s_first0 = s0_tlast;
      end
      if (s1_tvalid && s1_tready) begin
        exp_m1.push_back('{s1_tdata, s1_tlast});
        if (s_first1) begin exp_r1.push_back(64'h2A + 64'(jc)); jc++; grant_log.push_back(1); end
        s_first1 = s1_tlast;
      end
      if (p_in_tvalid && p_in_tready) begin
        pin_hs = 1'b1; nb.d = p_in_tdata; nb.l = p_in_tlast;
        if (pin_first) first_cyc.push_back(cyc);
        if (p_in_tlast) last_cyc.push_back(cyc);
        pin_first = p_in_tlast;
      end
      pout_hs = p_out_tvalid && p_out_tready;
      pout_last = p_out_tlast;
      if (m0_tvalid && m0_tready) begin
        m_beats0++; checks++;
        if (exp_m0.size() == 0) begin
          failures++; $display("FAIL m0_route: unexpected beat got=%h required=none", m0_tdata[31:0]);
        end else begin
          eb = exp_m0.pop_front();
          if (m0_tdata !== eb.d || m0_tlast !== eb.l) begin
            failures++; $display("FAIL m0_beat: got=%h/%b required=%h/%b", m0_tdata[31:0], m0_tlast, eb.d[31:0], eb.l);
          end
        end
        if (m0_tlast) m_order.push_back(0);
      end
      if (m1_tvalid && m1_tready) begin
        m_beats1++; checks++;
        if (exp_m1.size() == 0) begin
          failures++; $display("FAIL m1_route: unexpected beat got=%h required=none", m1_tdata[31:0]);
        end else begin
          eb = exp_m1.pop_front();
          if (m1_tdata !== eb.d || m1_tlast !== eb.l) begin
            failures++; $display("FAIL m1_beat: got=%h/%b required=%h/%b", m1_tdata[31:0], m1_tlast, eb.d[31:0], eb.l);
          end
        end
        if (m1_tlast) m_order.push_back(1);
      end
      if (r0_valid) begin
        r_seen0++; checks++;
        if (exp_r0.size() == 0) begin
          failures++; $display("FAIL r0_route: unexpected result got=%h required=none", r0_data);
        end else begin
          er = exp_r0.pop_front();
          if (r0_data !== er || r0_last !== 1'b1) begin
            failures++; $display("FAIL r0_result: got=%h/%b required=%h/1", r0_data, r0_last, er);
          end
        end
        r_order.push_back(0);
      end
      if (r1_valid) begin
        r_seen1++; checks++;
        if (exp_r1.size() == 0) begin
          failures++; $display("FAIL r1_route: unexpected result got=%h required=none", r1_data);
        end else begin
          er = exp_r1.pop_front();
          if (r1_data !== er || r1_last !== 1'b1) begin
            failures++; $display("FAIL r1_result: got=%h/%b required=%h/1", r1_data, r1_last, er);
          end
        end
        r_order.push_back(1);
      end
    end
    @(posedge aclk); #1;
    cyc++;
    p_res_valid = 1'b0; p_res_last = 1'b0;
    if (areset) begin
      pipe_q.delete(); exp_m0.delete(); exp_m1.delete(); exp_r0.delete(); exp_r1.delete();
      grant_log.delete(); m_order.delete(); r_order.delete(); first_cyc.delete(); last_cyc.delete();
      jc = 0; res_cnt = 0; s_first0 = 1'b1; s_first1 = 1'b1; pin_first = 1'b1;
      m_beats0 = 0; m_beats1 = 0; r_seen0 = 0; r_seen1 = 0;
    end else begin
      if (pout_hs) void'(pipe_q.pop_front());
      if (pin_hs) begin nb.t = cyc; pipe_q.push_back(nb); end
      if (pout_hs && pout_last) begin
        p_res_valid = 1'b1; p_res_last = 1'b1; p_res_data = 64'h2A + 64'(res_cnt); res_cnt++;
      end
    end
    if (orphan_req) begin
      p_res_valid = 1'b1; p_res_last = 1'b1; p_res_data = 64'h55; orphan_req = 1'b0;
    end
    if (pipe_q.size() > 0 && (cyc - pipe_q[0].t) >= pipe_delay) begin
      p_out_tvalid = 1'b1; p_out_tdata = pipe_q[0].d; p_out_tlast = pipe_q[0].l;
    end else begin
      p_out_tvalid = 1'b0; p_out_tlast = 1'b0;
    end
  end

  task automatic apply_reset();
    areset = 1'b1;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    en = 1'b1; m0_tready = 1'b1; m1_tready = 1'b1; pipe_delay = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic send_job(input int side, input int n, input logic [31:0] base);
    int waited;
    logic [31:0] w;
    for (int b = 0; b < n; b++) begin
      w = base + 32'(b);
      if (side == 0) begin s0_tvalid = 1'b1; s0_tdata = {16{w}}; s0_tlast = (b == n-1); end
      else           begin s1_tvalid = 1'b1; s1_tdata = {16{w}}; s1_tlast = (b == n-1); end
      waited = 0;
      forever begin
        @(negedge aclk);
        if ((side == 0) ? s0_tready : s1_tready) break;
        waited++;
        if (waited > 200) begin
          checks++; failures++;
          $display("FAIL send_timeout: side=%0d beat=%0d got=no tready required=tready", side, b);
          if (side == 0) s0_tvalid = 1'b0; else s1_tvalid = 1'b0;
          return;
        end
      end
      @(posedge aclk); #1;
    end
    if (side == 0) begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    else           begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int w = 0;
    while ((exp_m0.size() + exp_m1.size() + exp_r0.size() + exp_r1.size() + pipe_q.size()) != 0 && w < budget) begin
      @(negedge aclk); w++;
    end
    checks++;
    if ((exp_m0.size() + exp_m1.size() + exp_r0.size() + exp_r1.size() + pipe_q.size()) != 0) begin
      failures++;
      $display("FAIL %s_drain: pending m0=%0d m1=%0d r0=%0d r1=%0d pipe=%0d required all 0",
               nm, exp_m0.size(), exp_m1.size(), exp_r0.size(), exp_r1.size(), pipe_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #1 areset = 1'b1;
    #2;
    v = {s0_tready, s1_tready, p_in_tvalid, p_out_tready, m0_tvalid, m1_tvalid, r0_valid, r1_valid};
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_handshakes: got=%b required=00000000", v); end
    checks++; if (jobs0 !== 32'd0 || jobs1 !== 32'd0) begin failures++; $display("FAIL reset_jobs: got=%0d/%0d required=0/0", jobs0, jobs1); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_orphan: got=%b required=0", err_orphan); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    fork
      send_job(0, 4, 32'h100);
      begin
        @(negedge aclk);
        checks++; if (s0_tready !== 1'b0) begin failures++; $display("FAIL grant_idle: got tready=%b required=0", s0_tready); end
        @(negedge aclk);
        checks++; if (s0_tready !== 1'b1) begin failures++; $display("FAIL grant_latency: got tready=%b required=1", s0_tready); end
      end
    join
    wait_drain("single", 100);
    checks++; if (jobs0 !== 32'd1 || jobs1 !== 32'd0) begin failures++; $display("FAIL single_jobs: got=%0d/%0d required=1/0", jobs0, jobs1); end
    checks++; if (m_beats0 != 4 || m_beats1 != 0) begin failures++; $display("FAIL single_beats: got=%0d/%0d required=4/0", m_beats0, m_beats1); end
    checks++; if (r_seen0 != 1 || r_seen1 != 0) begin failures++; $display("FAIL single_results: got=%0d/%0d required=1/0", r_seen0, r_seen1); end
  endtask

  task automatic test_contention();
    int exp_g[4] = '{0, 1, 0, 1};
    apply_reset();
    fork
      begin send_job(0, 2, 32'h200); send_job(0, 2, 32'h210); end
      begin send_job(1, 2, 32'h300); send_job(1, 2, 32'h310); end
    join
    wait_drain("contention", 200);
    checks++;
    if (grant_log.size() != 4) begin
      failures++; $display("FAIL contention_grants: got count=%0d required=4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++)
        if (grant_log[k] != exp_g[k]) begin
          failures++; $display("FAIL contention_order: job=%0d got=%0d required=%0d", k, grant_log[k], exp_g[k]); break;
        end
    end
    checks++;
    if (first_cyc.size() != 4 || last_cyc.size() != 4) begin
      failures++; $display("FAIL contention_bubble: got first/last=%0d/%0d required=4/4", first_cyc.size(), last_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++)
        if (first_cyc[k+1] - last_cyc[k] != 2) begin
          failures++; $display("FAIL contention_bubble: job=%0d got gap=%0d required=2", k, first_cyc[k+1] - last_cyc[k]); break;
        end
    end
    checks++; if (jobs0 !== 32'd2 || jobs1 !== 32'd2) begin failures++; $display("FAIL contention_jobs: got=%0d/%0d required=2/2", jobs0, jobs1); end
  endtask

  task automatic test_ordering();
    apply_reset();
    pipe_delay = 20;
    send_job(1, 2, 32'h400);
    send_job(0, 2, 32'h500);
    wait_drain("ordering", 200);
    checks++;
    if (m_order.size() != 2 || m_order[0] != 1 || m_order[1] != 0) begin
      failures++; $display("FAIL ordering_stream: got count=%0d first=%0d required first=1 second=0", m_order.size(), (m_order.size() > 0) ? m_order[0] : -1);
    end
    checks++;
    if (r_order.size() != 2 || r_order[0] != 1 || r_order[1] != 0) begin
      failures++; $display("FAIL ordering_scalar: got count=%0d first=%0d required first=1 second=0", r_order.size(), (r_order.size() > 0) ? r_order[0] : -1);
    end
    pipe_delay = 0;
  endtask

  task automatic test_full();
    int w;
    apply_reset();
    m0_tready = 1'b0; m1_tready = 1'b0;
    fork
      begin
        for (int j = 0; j < 9; j++) send_job(0, 1, 32'h600 + 32'(j));
      end
      begin
        repeat (40) @(posedge aclk);
        @(negedge aclk);
        checks++; if (jobs0 !== 32'd8) begin failures++; $display("FAIL full_grants: got=%0d required=8", jobs0); end
        checks++; if (s0_tready !== 1'b0 || s0_tvalid !== 1'b1) begin failures++; $display("FAIL full_blocked: got tready=%b tvalid=%b required 0/1", s0_tready, s0_tvalid); end
        @(posedge aclk); #1;
        m0_tready = 1'b1;
        w = 0;
        while (jobs0 !== 32'd9 && w < 20) begin @(negedge aclk); w++; end
        checks++; if (jobs0 !== 32'd9) begin failures++; $display("FAIL full_release: got=%0d required=9", jobs0); end
      end
    join
    wait_drain("full", 200);
    m1_tready = 1'b1;
  endtask

  task automatic test_enable_orphan();
    int bad = 0;
    apply_reset();
    en = 1'b0;
    s0_tvalid = 1'b1; s0_tdata = {16{32'h7777}}; s0_tlast = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = {16{32'h8888}}; s1_tlast = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      if (s0_tready || s1_tready || p_in_tvalid) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL enable_tready: got %0d cycles with tready required 0", bad); end
    checks++; if (jobs0 !== 32'd0 || jobs1 !== 32'd0) begin failures++; $display("FAIL enable_jobs: got=%0d/%0d required=0/0", jobs0, jobs1); end
    @(posedge aclk); #1;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    en = 1'b1;
    @(negedge aclk);
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_pre: got=%b required=0", err_orphan); end
    orphan_req = 1'b1;
    @(posedge aclk); #2;
    @(negedge aclk);
    checks++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin failures++; $display("FAIL orphan_valid: got=%b/%b required=0/0", r0_valid, r1_valid); end
    @(posedge aclk); #2;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_set: got=%b required=1", err_orphan); end
    repeat (3) @(posedge aclk);
    #2;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky: got=%b required=1", err_orphan); end
  endtask

  task automatic test_reset_midjob();
    logic [7:0] v;
    apply_reset();
    s0_tvalid = 1'b1; s0_tdata = {16{32'h900}}; s0_tlast = 1'b0;
    @(negedge aclk);
    @(posedge aclk); #1;
    @(negedge aclk);
    @(posedge aclk); #1;
    s0_tdata = {16{32'h901}};
    #2 areset = 1'b1;
    #1;
    v = {s0_tready, s1_tready, p_in_tvalid, p_out_tready, m0_tvalid, m1_tvalid, r0_valid, r1_valid};
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL midreset_handshakes: got=%b required=00000000", v); end
    checks++; if (jobs0 !== 32'd0 || jobs1 !== 32'd0) begin failures++; $display("FAIL midreset_jobs: got=%0d/%0d required=0/0", jobs0, jobs1); end
    s0_tvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk); #1;
    send_job(1, 2, 32'hA00);
    wait_drain("midreset", 100);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 1) begin
      failures++; $display("FAIL midreset_grant: got count=%0d first=%0d required 1/1", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    checks++; if (jobs0 !== 32'd0 || jobs1 !== 32'd1) begin failures++; $display("FAIL midreset_after: got=%0d/%0d required=0/1", jobs0, jobs1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_ordering();
    test_full();
    test_enable_orphan();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reduction_job_arbiter.md
# reduction_job_arbiter

Shares one streaming reduction pipeline (512-bit data stream in, 512-bit pass-through stream out, 64-bit scalar result side-channel) between two host requester streams at job granularity. A job is a packet terminated by `tlast`. The block grants the pipeline input to one requester per job in round-robin order and records the owner in tag FIFOs. It then steers the pipeline's output stream and scalar results back to the owning requester in job order. It sits in user logic between the host stream interfaces and the reduction core.

## Interface
Parameters:
- `DATA_BITS`, 512, stream data width.
- `RES_BITS`, 64, scalar result width.
- `TAG_DEPTH`, 8, jobs in flight per tag FIFO; power of two, ≥2.

Ports:
- `aclk` in 1: single clock.
- `areset` in 1: reset, asynchronous, active-high.
- `en` in 1: arbitration enable.
- `s0_tvalid`/`s1_tvalid` in 1; `s0_tready`/`s1_tready` out 1; `s0_tdata`/`s1_tdata` in DATA_BITS; `s0_tlast`/`s1_tlast` in 1: requester input streams.
- `p_in_tvalid` out 1, `p_in_tready` in 1, `p_in_tdata` out DATA_BITS, `p_in_tlast` out 1: pipeline input.
- `p_out_tvalid` in 1, `p_out_tready` out 1, `p_out_tdata` in DATA_BITS, `p_out_tlast` in 1: pipeline output stream.
- `p_res_valid` in 1, `p_res_data` in RES_BITS, `p_res_last` in 1: pipeline scalar result. No backpressure.
- `m0_*`/`m1_*` (`tvalid` out, `tready` in, `tdata` out DATA_BITS, `tlast` out): per-requester result streams.
- `r0_valid`/`r1_valid` out 1, `r0_data`/`r1_data` out RES_BITS, `r0_last`/`r1_last` out 1: per-requester scalar results.
- `jobs0`/`jobs1` out 32: jobs granted per requester; wrap at 2^32.
- `err_orphan` out 1: sticky. Set when a scalar result arrives with no job outstanding.

## Operation
- Arbiter FSM has two states:
  - `IDLE`: no grant; `p_in_tvalid`=0; both `s*_tready`=0.
  - `BUSY`: holds a registered `owner`.
- IDLE→BUSY requires all of: `en`=1, some `s*_tvalid`=1, and neither tag FIFO full.
  - Winner is `rr` if `s[rr]_tvalid`, else the other requester.
  - On the transition: `owner`←winner, the tag is pushed into both FIFOs (`out_fifo`, `res_fifo`), and `jobs[winner]` increments.
- BUSY forwarding is combinational:
  - `p_in_tvalid`=`s[owner]_tvalid`; `p_in_tdata`/`p_in_tlast` come from the owner.
  - `s[owner]_tready`=`p_in_tready`; the non-owner `tready`=0.
- BUSY→IDLE on a `p_in` handshake with `p_in_tlast`=1; `rr`←`~owner`.
- `en` deasserted during BUSY has no effect until the job ends; no new grant follows while `en`=0.
- Output-stream steering:
  - `head`=`out_fifo` front.
  - `m[head]_tvalid`=`p_out_tvalid & ~out_empty`; the other `m*_tvalid`=0.
  - `p_out_tready`=`m[head]_tready & ~out_empty`.
  - Pop on a `p_out` handshake with `p_out_tlast`.
  - While `out_fifo` is empty, `p_out` stalls (`p_out_tready`=0).
- Scalar steering:
  - `r[h]_valid`=`p_res_valid & ~res_empty`, where `h` is the `res_fifo` front.
  - `r*_data`/`r*_last` are driven from `p_res_*` to both requesters, qualified by valid.
  - Pop when `p_res_valid & p_res_last`.
  - `p_res_valid` with `res_fifo` empty → result dropped, `err_orphan`←1.
- Simultaneous push and pop on a FIFO in the same cycle is legal at any occupancy except a push when full, which the grant condition excludes. Pointers wrap modulo TAG_DEPTH.

## Timing
- Reset values:
  - State and counts: state=IDLE, `rr`=0, `owner`=0, FIFOs empty, `jobs*`=0, `err_orphan`=0.
  - Outputs: all `*_tvalid`/`*_valid`/`*_tready`=0.
- Grant latency: 1 cycle. The first beat of a job can transfer no earlier than the cycle after IDLE sees the request.
- Each job costs exactly one bubble cycle on `p_in` (the IDLE cycle).
- Data paths carry zero cycles of latency. Only FSM state, `owner`, `rr`, FIFO pointers, counters and `err_orphan` are registered.
- Tags are visible at FIFO heads one cycle after the push, which is the same cycle as the first possible `p_in` beat.
- Reset asserted mid-job discards the in-flight job and all queued tags. Outputs go to reset values immediately (asynchronous).

## Test plan
- Single job: s0 sends 4 beats (last on beat 4) and the pipeline echoes them. Required: grant 1 cycle after `s0_tvalid`; 4 beats on m0, none on m1; `jobs0`=1; `r0_valid` pulse with `r0_last`=1 and the pipeline's value (e.g. 0x2A).
- Contention: s0 and s1 both hold 2-beat jobs continuously. Required:
  - Grants alternate s0,s1,s0,s1.
  - `p_in` shows one idle cycle between jobs.
  - After 4 jobs, `jobs0`=`jobs1`=2.
- Ordering: s1 job then s0 job issued, with results delayed 20 cycles. Required: first result packet and scalar go to m1/r1, second to m0/r0.
- Backpressure and full: hold `m*_tready`=0 and inject 9 one-beat jobs with TAG_DEPTH=8. Required:
  - Exactly 8 grants; the 9th requester stays `tready`=0.
  - After releasing `tready` and one tlast pop, the 9th is granted.
- Orphan and enable: with `en`=0, requests see `tready`=0 for 10 cycles and `jobs*` are unchanged. Then a `p_res_valid` pulse with no job outstanding gives `err_orphan`=1 and both `r*_valid` stay 0.
- Reset mid-job: assert `areset` during beat 2 of a 4-beat s0 job. Required: all valids/readies 0 and counters 0 in the same cycle; after release, a new s1 job is granted first (`rr`=0 with only s1 valid).
